// File: rtl/decryption_pkg.sv
// Shared constants and state encoding for the scytale decryption stage.
package decryption_pkg;
  localparam int D_WIDTH_DEF       = 8;
  localparam int KEY_WIDTH_DEF     = 8;
  localparam int MAX_NOF_CHARS_DEF = 50;
  localparam logic [7:0] START_DECRYPTION_TOKEN = 8'hFA;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DECRYPT = 2'd1,
    DONE    = 2'd2
  } state_t;
endpackage

// File: rtl/division.sv
// Combinational unsigned divider; a zero divisor yields zero quotient and remainder.
module division #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);
  always_comb begin
    q = '0;
    r = '0;
    if (d != '0) begin
      q = n / d;
      r = n % d;
    end
  end
endmodule

// File: rtl/scytale_decryption.sv
// Collects ciphertext until the start token, then emits plaintext one char per clock.
// Handshake: valid_i is sampled only when busy is low; valid_o pulses once per emitted char.
module scytale_decryption
  import decryption_pkg::*;
#(
  parameter int D_WIDTH       = D_WIDTH_DEF,
  parameter int KEY_WIDTH     = KEY_WIDTH_DEF,
  parameter int MAX_NOF_CHARS = MAX_NOF_CHARS_DEF,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = decryption_pkg::START_DECRYPTION_TOKEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key_N,
  input  logic [KEY_WIDTH-1:0] key_M,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  output logic                 busy
);
  localparam int SRC_W = 2 * KEY_WIDTH;
  localparam int IDX_W = $clog2(MAX_NOF_CHARS);

  state_t               state_q, state_d;
  logic [KEY_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [KEY_WIDTH-1:0] rd_idx_q, rd_idx_d;
  logic [D_WIDTH-1:0]   data_o_q, data_o_d;
  logic                 valid_o_q, valid_o_d;
  logic                 busy_q, busy_d;
  logic                 buf_we;

  logic [D_WIDTH-1:0]   mem_q [MAX_NOF_CHARS];
  logic [KEY_WIDTH-1:0] div_q, div_r;
  logic [SRC_W-1:0]     src;
  logic [IDX_W-1:0]     src_idx;

  division #(.WIDTH(KEY_WIDTH)) u_division (
    .n (rd_idx_q),
    .d (key_N),
    .q (div_q),
    .r (div_r)
  );

  // Column-major read-back: row R of the wrapped strip, column Q.
  assign src     = SRC_W'(div_r) * SRC_W'(key_M) + SRC_W'(div_q);
  assign src_idx = src[IDX_W-1:0];

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_idx_d  = rd_idx_q;
    data_o_d  = data_o_q;
    valid_o_d = 1'b0;
    busy_d    = busy_q;
    buf_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (data_i == START_DECRYPTION_TOKEN) begin
            state_d  = DECRYPT;
            busy_d   = 1'b1;
            rd_idx_d = '0;
          end else if (wr_cnt_q < KEY_WIDTH'(MAX_NOF_CHARS)) begin
            buf_we   = 1'b1;
            wr_cnt_d = wr_cnt_q + KEY_WIDTH'(1);
          end
        end
      end
      DECRYPT: begin
        if (wr_cnt_q == '0) begin
          state_d = DONE;
        end else begin
          data_o_d  = (src < SRC_W'(wr_cnt_q)) ? mem_q[src_idx] : '0;
          valid_o_d = 1'b1;
          rd_idx_d  = rd_idx_q + KEY_WIDTH'(1);
          if (rd_idx_q == wr_cnt_q - KEY_WIDTH'(1)) state_d = DONE;
        end
      end
      DONE: begin
        busy_d   = 1'b0;
        wr_cnt_d = '0;
        data_o_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_cnt_q  <= '0;
      rd_idx_q  <= '0;
      data_o_q  <= '0;
      valid_o_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_idx_q  <= rd_idx_d;
      data_o_q  <= data_o_d;
      valid_o_q <= valid_o_d;
      busy_q    <= busy_d;
    end
  end

  // Buffer contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (buf_we) mem_q[wr_cnt_q[IDX_W-1:0]] <= data_i;
  end

  assign data_o  = data_o_q;
  assign valid_o = valid_o_q;
  assign busy    = busy_q;
endmodule

// File: tb/tb_scytale_decryption.sv
// Bench for scytale_decryption: directed and random messages against a scytale reference model.
module tb_scytale_decryption;
  localparam logic [7:0] TOKEN = 8'hFA;
  localparam int MAXC = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_i;
  logic       valid_i;
  logic [7:0] key_n, key_m;
  logic [7:0] data_o;
  logic       valid_o;
  logic       busy;

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] msg_q[$];
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  scytale_decryption dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .valid_i (valid_i),
    .key_N   (key_n),
    .key_M   (key_m),
    .data_o  (data_o),
    .valid_o (valid_o),
    .busy    (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: plaintext position i comes from strip cell (i mod N)*M + (i div N).
  task automatic build_expected(input int kn, input int km);
    int n, q, r, src;
    n = model_q.size();
    exp_q = {};
    for (int i = 0; i < n; i++) begin
      q = (kn == 0) ? 0 : i / kn;
      r = (kn == 0) ? 0 : i % kn;
      src = r * km + q;
      exp_q.push_back((src < n) ? model_q[src] : 8'h00);
    end
  endtask

  task automatic load_str(input string s);
    msg_q = {};
    for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
  endtask

  task automatic drive_busy_noise(input bit inject);
    valid_i = inject;
    data_i  = ($urandom_range(0, 1) == 0) ? 8'h5A : TOKEN;
  endtask

  task automatic send_chars(input int gap_max);
    model_q = {};
    foreach (msg_q[i]) begin
      @(negedge clk);
      valid_i = 1'b1;
      data_i  = msg_q[i];
      if (model_q.size() < MAXC) model_q.push_back(msg_q[i]);
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          @(negedge clk);
          valid_i = 1'b0;
          data_i  = 8'h00;
        end
      end
    end
    @(negedge clk);
    valid_i = 1'b1;
    data_i  = TOKEN;
  endtask

  task automatic run_msg(input string name, input logic [7:0] kn, input logic [7:0] km,
                         input bit inject, input int gap_max);
    key_n = kn;
    key_m = km;
    send_chars(gap_max);
    build_expected(int'(kn), int'(km));
    @(negedge clk);
    chk({name, ".busy_after_token"}, busy, 1);
    chk({name, ".valid_after_token"}, valid_o, 0);
    drive_busy_noise(inject);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      chk($sformatf("%s.valid[%0d]", name, k), valid_o, 1);
      chk($sformatf("%s.data[%0d]", name, k), data_o, exp_q[k]);
      chk($sformatf("%s.busy[%0d]", name, k), busy, 1);
      drive_busy_noise(inject);
    end
    if (exp_q.size() == 0) begin
      @(negedge clk);
      chk({name, ".busy_2nd"}, busy, 1);
      chk({name, ".valid_2nd"}, valid_o, 0);
      drive_busy_noise(inject);
    end
    @(negedge clk);
    chk({name, ".busy_end"}, busy, 0);
    chk({name, ".valid_end"}, valid_o, 0);
    chk({name, ".data_end"}, data_o, 0);
    valid_i = 1'b0;
    data_i  = 8'h00;
  endtask

  initial begin
    string exp_str;
    rst     = 1'b1;
    valid_i = 1'b0;
    data_i  = 8'h00;
    key_n   = 8'd0;
    key_m   = 8'd0;
    repeat (2) @(negedge clk);
    chk("reset.valid", valid_o, 0);
    chk("reset.busy", busy, 0);
    chk("reset.data", data_o, 0);
    rst = 1'b0;

    // Basic 4x2 strip with busy-time noise that must be ignored.
    load_str("AEBFCGDH");
    run_msg("basic", 8'd4, 8'd2, 1'b1, 0);
    exp_str = "ABCDEFGH";
    foreach (exp_q[i]) chk($sformatf("basic.plain[%0d]", i), exp_q[i], exp_str[i]);

    // Token with an empty buffer also proves the noise left nothing behind.
    msg_q = {};
    run_msg("empty", 8'd4, 8'd2, 1'b0, 0);

    // Overflow: only the first MAXC chars are kept.
    msg_q = {};
    for (int i = 1; i <= 55; i++) msg_q.push_back(8'(i));
    run_msg("overflow", 8'd1, 8'd50, 1'b0, 0);
    chk("overflow.count", exp_q.size(), 50);

    load_str("XYZ");
    run_msg("keyn0", 8'd0, 8'd3, 1'b0, 0);

    // Reset on the third decrypt cycle aborts the message.
    load_str("AEBFCGDH");
    key_n = 8'd4;
    key_m = 8'd2;
    send_chars(0);
    @(negedge clk);
    valid_i = 1'b0;
    chk("abort.busy", busy, 1);
    @(negedge clk);
    chk("abort.out0", data_o, "A");
    @(negedge clk);
    chk("abort.out1", data_o, "B");
    rst = 1'b1;
    @(negedge clk);
    chk("abort.valid", valid_o, 0);
    chk("abort.busy_low", busy, 0);
    rst = 1'b0;
    load_str("AB");
    run_msg("after_rst", 8'd1, 8'd2, 1'b0, 0);

    for (int t = 0; t < 8; t++) begin
      int len;
      logic [7:0] c;
      len = $urandom_range(0, 55);
      msg_q = {};
      for (int i = 0; i < len; i++) begin
        c = 8'($urandom_range(0, 255));
        if (c == TOKEN) c = 8'h00;
        msg_q.push_back(c);
      end
      run_msg($sformatf("rand%0d", t), 8'($urandom_range(0, 9)), 8'($urandom_range(0, 9)),
              1'($urandom_range(0, 1)), 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/scytale_decryption.md
Name: scytale_decryption

Overview:
- Sequential decryption stage that consumes the quotient/remainder of the combinational `division` block.
- Buffers a stream of ciphertext characters until a start token arrives. It then emits the plaintext one character per clock.
- Output position i reads buffer[(i mod key_N)*key_M + (i div key_N)]. The div/mod pair comes from an internal `division` instance.
- Sits between the byte-stream input mux and the output demux of the decryption path.

Parameters:
- D_WIDTH, 8, character width in bits
- KEY_WIDTH, 8, width of key_N/key_M and of the internal index/division datapath
- MAX_NOF_CHARS, 50, buffer depth in characters
- START_DECRYPTION_TOKEN, 8'hFA, input value that ends collection and starts decryption

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- data_i  input  D_WIDTH  ciphertext character
- valid_i  input  1  data_i qualifier
- key_N  input  KEY_WIDTH  scytale column count (divisor)
- key_M  input  KEY_WIDTH  scytale row count
- data_o  output  D_WIDTH  plaintext character
- valid_o  output  1  data_o qualifier, one pulse per character
- busy  output  1  high while emitting; inputs ignored

Interface:
- One clock. Reset is synchronous and active-high; ports named clk and rst.
- All outputs are registered.

Behaviour:
- Reset values: data_o=0, valid_o=0, busy=0, wr_cnt=0, rd_idx=0, state=IDLE. Buffer contents are don't-care.
- Reset mid-operation aborts decryption and discards the buffer. There are no outputs in the cycle after reset.
- States: IDLE (collect), DECRYPT (emit), DONE (one cleanup cycle).
- IDLE, valid_i=1, data_i != token:
  - If wr_cnt < MAX_NOF_CHARS: buffer[wr_cnt] <= data_i; wr_cnt++.
  - Otherwise the write is dropped silently; wr_cnt saturates.
- IDLE, valid_i=1, data_i == token: the token is not stored; state <= DECRYPT; busy <= 1; rd_idx <= 0.
- DECRYPT, each cycle:
  - division N=rd_idx, D=key_N gives Q, R.
  - src = R*key_M + Q, computed at 2*KEY_WIDTH and then compared.
  - data_o <= (src < wr_cnt) ? buffer[src] : 0.
  - valid_o <= 1; rd_idx++.
  - When rd_idx == wr_cnt-1 the last character is issued and the next state is DONE.
- DONE: valid_o <= 0; busy <= 0; wr_cnt <= 0; data_o <= 0; state <= IDLE.
- Latency and handshake:
  - Token sampled at edge t: busy=1 after edge t.
  - First valid_o is high after edge t+1. wr_cnt consecutive valid_o pulses follow, with no gaps.
  - busy falls and valid_o falls after the same edge, the one following the last character.
- valid_i while busy=1 is ignored, including a token.
- Token with wr_cnt=0: DECRYPT emits nothing and goes straight to DONE. busy is high for 2 cycles; valid_o never asserts.
- key_N=0: division yields Q=R=0, so every output is buffer[0]. This is defined behaviour, not an error.
- key_N*key_M != wr_cnt is legal. Any src >= wr_cnt outputs 0x00.
- key_N/key_M are sampled combinationally each DECRYPT cycle. The source must hold them stable from token until busy falls.

Decomposition:
- Package `decryption_pkg`:
  - START_DECRYPTION_TOKEN
  - state encoding localparams: IDLE=2'd0, DECRYPT=2'd1, DONE=2'd2
  - default D_WIDTH/KEY_WIDTH
- Sub-module: the existing `division` block, one instance, width=KEY_WIDTH, N=rd_idx, D=key_N. No other sub-module.
- Buffer is a register array, with no RAM macro.

Test Plan:
- key_N=4, key_M=2; send "AEBFCGDH" then 0xFA -> busy high the next cycle; valid_o on 8 consecutive cycles carrying "ABCDEFGH"; busy and valid_o low together afterwards.
- Token only, no characters -> busy high 2 cycles; valid_o stays 0; wr_cnt back to 0.
- 55 characters (0x01..0x37), key_N=1, key_M=50, then token -> exactly 50 outputs 0x01..0x32; characters 51-55 dropped.
- During DECRYPT of the first test, drive valid_i with 'Z' and 0xFA -> output unchanged; the next message is collected from empty.
- key_N=0, buffer "XYZ", token -> three outputs, all 'X'.
- rst asserted on the 3rd DECRYPT cycle -> next cycle valid_o=0, busy=0. A subsequent message "AB", key_N=1, key_M=2 -> outputs "AB".
